// File: rtl/fb_pixel_writer.sv
// Framebuffer writer: each drawer plot strobe becomes one linear write; clear sweep; optional CLIP_COUNT_EN clip counter.
// Outputs are registered, so a write appears one cycle after its plot. There is no backpressure: one write per cycle, and plots are dropped outside IDLE.
module fb_pixel_writer #(
   parameter int unsigned H_RES  = 160,
   parameter int unsigned V_RES  = 120,
   parameter int unsigned ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_x,
   input  logic [6:0]        in_y,
   input  logic [2:0]        in_colour,
   input  logic              in_plot,
   input  logic              clear_start,
   input  logic [2:0]        clear_colour,
   output logic              clear_done,
   output logic              busy,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [2:0]        fb_data,
   output logic              fb_we
`ifdef CLIP_COUNT_EN
   ,
   output logic [15:0]       clip_count
`endif
);

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   localparam int unsigned TOTAL = H_RES * V_RES;
   localparam int unsigned AW1   = ADDR_W + 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [2:0]        colour_q, colour_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [2:0]        fb_data_q, fb_data_d;
   logic              fb_we_q, fb_we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W:0]   lin_addr;
   logic              on_screen;
   logic              last_wr;

   // One spare bit keeps an off-screen product from wrapping onto a valid address.
   assign lin_addr  = AW1'(in_y) * AW1'(H_RES) + AW1'(in_x);
   assign on_screen = (32'(in_x) < H_RES) && (32'(in_y) < V_RES) && (32'(lin_addr) < TOTAL);
   assign last_wr   = (cnt_q == ADDR_W'(TOTAL - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (clear_start) state_d = CLEAR;
         CLEAR:   if (last_wr) state_d = DONE;
         DONE:    if (!clear_start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fb_we_d   = 1'b0;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      cnt_d     = cnt_q;
      colour_d  = colour_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (clear_start) begin
               colour_d = clear_colour;
            end else if (in_plot && on_screen) begin
               fb_we_d   = 1'b1;
               fb_addr_d = lin_addr[ADDR_W-1:0];
               fb_data_d = in_colour;
            end
         end
         CLEAR: begin
            fb_we_d   = 1'b1;
            fb_addr_d = cnt_q;
            fb_data_d = colour_q;
            busy_d    = 1'b1;
            cnt_d     = cnt_q + ADDR_W'(1);
         end
         DONE:    done_d = clear_start;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         colour_q  <= '0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
         fb_we_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         colour_q  <= colour_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
         fb_we_q   <= fb_we_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign fb_addr    = fb_addr_q;
   assign fb_data    = fb_data_q;
   assign fb_we      = fb_we_q;
   assign busy       = busy_q;
   assign clear_done = done_q;

`ifdef CLIP_COUNT_EN
   logic        clip_inc;
   logic [15:0] clip_q;

   assign clip_inc = (state_q == IDLE) && !clear_start && in_plot && !on_screen;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               clip_q <= '0;
      else if (clip_inc && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
   end

   assign clip_count = clip_q;
`endif

endmodule
